// File: rtl/accel_angle_cordic.sv
// Accelerometer tilt front end: two sequential vectoring-mode CORDIC passes give
// phi = atan2(ay, az) and theta = atan2(-ax, |(ay, az)|). Optional IIR smoothing: ACC_ANGLE_LPF_EN.
module accel_angle_cordic #(
  parameter int ITER      = 14,
  parameter int IW        = 20,
  parameter int LPF_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  input  logic signed [15:0] az,
  output logic signed [15:0] theta_acc,
  output logic signed [15:0] phi_acc,
  output logic               done,
  output logic               busy,
  output logic               sat
);

  localparam int ZW = 18;
  localparam logic signed [ZW-1:0] PI_2     = 18'sd25736;
  localparam logic signed [15:0]   INV_GAIN = 16'sd9949;

  typedef enum logic [2:0] {IDLE, PRE1, ROT1, SCALE, PRE2, ROT2, DONE} state_t;
  state_t state, state_nxt;

  logic signed [15:0]    ax_r, ay_r, az_r, neg_ax;
  logic signed [IW-1:0]  x, y, m;
  logic signed [ZW-1:0]  z, phi_int;
  logic [3:0]            iter;
  logic                  zero_vec, last_iter;
  logic signed [IW-1:0]  op_x, op_y, pre_x, pre_y, x_sh, y_sh, x_rot, y_rot;
  logic signed [ZW-1:0]  pre_z, z_rot, theta_new;
  logic signed [IW+15:0] x_ext, k_ext, prod;
  logic [16:0]           phi_s, theta_s;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 18'sd12868;
      4'd1:    return 18'sd7596;
      4'd2:    return 18'sd4014;
      4'd3:    return 18'sd2037;
      4'd4:    return 18'sd1023;
      4'd5:    return 18'sd512;
      4'd6:    return 18'sd256;
      4'd7:    return 18'sd128;
      4'd8:    return 18'sd64;
      4'd9:    return 18'sd32;
      4'd10:   return 18'sd16;
      4'd11:   return 18'sd8;
      4'd12:   return 18'sd4;
      4'd13:   return 18'sd2;
      default: return '0;
    endcase
  endfunction

  // Returns {clipped, saturated 16-bit value}
  function automatic logic [16:0] sat16(input logic signed [ZW-1:0] v);
    if (v > 18'sd32767)       return {1'b1, 16'h7FFF};
    else if (v < -18'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, v[15:0]};
  endfunction

  assign busy      = (state != IDLE);
  assign last_iter = (iter == 4'(ITER - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = PRE1;
      PRE1:    state_nxt = ROT1;
      ROT1:    if (last_iter) state_nxt = SCALE;
      SCALE:   state_nxt = PRE2;
      PRE2:    state_nxt = ROT2;
      ROT2:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand select, quadrant fold into the right half-plane, one micro-rotation, gain removal
  always_comb begin
    neg_ax = (ax_r == 16'sh8000) ? 16'sh7FFF : -ax_r;
    if (state == PRE1) begin
      op_x = {{(IW-16){az_r[15]}}, az_r};
      op_y = {{(IW-16){ay_r[15]}}, ay_r};
    end else begin
      op_x = m;
      op_y = {{(IW-16){neg_ax[15]}}, neg_ax};
    end
    pre_x = op_x;
    pre_y = op_y;
    pre_z = '0;
    if (op_x[IW-1]) begin
      if (!op_y[IW-1]) begin
        pre_x = op_y;
        pre_y = -op_x;
        pre_z = PI_2;
      end else begin
        pre_x = -op_y;
        pre_y = op_x;
        pre_z = -PI_2;
      end
    end
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    if (!y[IW-1]) begin
      x_rot = x + y_sh;
      y_rot = y - x_sh;
      z_rot = z + atan_lut(iter);
    end else begin
      x_rot = x - y_sh;
      y_rot = y + x_sh;
      z_rot = z - atan_lut(iter);
    end
    x_ext     = {{16{x[IW-1]}}, x};
    k_ext     = {{IW{1'b0}}, INV_GAIN};
    prod      = x_ext * k_ext;
    theta_new = zero_vec ? '0 : z;
    phi_s     = sat16(phi_int);
    theta_s   = sat16(theta_new);
  end

`ifdef ACC_ANGLE_LPF_EN
  logic               lpf_primed;
  logic signed [16:0] phi_diff, theta_diff, phi_filt, theta_filt;
  logic               unused_bits;

  always_comb begin
    phi_diff   = {phi_s[15], phi_s[15:0]} - {phi_acc[15], phi_acc};
    theta_diff = {theta_s[15], theta_s[15:0]} - {theta_acc[15], theta_acc};
    phi_filt   = {phi_acc[15], phi_acc} + (phi_diff >>> LPF_SHIFT);
    theta_filt = {theta_acc[15], theta_acc} + (theta_diff >>> LPF_SHIFT);
  end
  assign unused_bits = ^{prod[IW+15:IW+14], prod[13:0], phi_filt[16], theta_filt[16]};
`else
  logic unused_bits;
  assign unused_bits = ^{prod[IW+15:IW+14], prod[13:0], (LPF_SHIFT > 0)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ax_r <= '0; ay_r <= '0; az_r <= '0;
      x <= '0; y <= '0; z <= '0; m <= '0;
      phi_int <= '0; iter <= '0; zero_vec <= 1'b0;
      theta_acc <= '0; phi_acc <= '0;
      done <= 1'b0; sat <= 1'b0;
`ifdef ACC_ANGLE_LPF_EN
      lpf_primed <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ax_r <= ax; ay_r <= ay; az_r <= az;
          sat  <= 1'b0;
        end
        PRE1, PRE2: begin
          x        <= pre_x;
          y        <= pre_y;
          z        <= pre_z;
          zero_vec <= (op_x == '0) && (op_y == '0);
          iter     <= '0;
        end
        ROT1, ROT2: begin
          x    <= x_rot;
          y    <= y_rot;
          z    <= z_rot;
          iter <= iter + 4'd1;
        end
        SCALE: begin
          m       <= prod[IW+13:14];
          phi_int <= zero_vec ? '0 : z;
        end
        DONE: begin
          done <= 1'b1;
          sat  <= phi_s[16] | theta_s[16];
`ifdef ACC_ANGLE_LPF_EN
          if (!lpf_primed) begin
            phi_acc    <= phi_s[15:0];
            theta_acc  <= theta_s[15:0];
            lpf_primed <= 1'b1;
          end else begin
            phi_acc    <= phi_filt[15:0];
            theta_acc  <= theta_filt[15:0];
          end
`else
          phi_acc   <= phi_s[15:0];
          theta_acc <= theta_s[15:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_angle_cordic.sv
// Directed-vector bench for accel_angle_cordic: table of angles plus start-ignore and reset-abort sequences.
module tb_accel_angle_cordic;

  logic               clk = 1'b0;
  logic               reset, start;
  logic signed [15:0] ax, ay, az;
  logic signed [15:0] theta_acc, phi_acc;
  logic               done, busy, sat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string              name;
    logic signed [15:0] ax, ay, az;
    int                 exp_theta, tol_theta;
    int                 exp_phi, tol_phi;
    int                 exp_sat;
  } vec_t;

  vec_t vecs[10];

  accel_angle_cordic dut (
    .clk(clk), .reset(reset), .start(start),
    .ax(ax), .ay(ay), .az(az),
    .theta_acc(theta_acc), .phi_acc(phi_acc),
    .done(done), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    total++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", name, actual, expected, tol);
    end
  endtask

  // Pulses start with the given sample and returns the number of clocks until done (-1 on timeout)
  task automatic applyStimulus(input logic signed [15:0] vx, input logic signed [15:0] vy,
                               input logic signed [15:0] vz, output int lat);
    lat = -1;
    @(negedge clk);
    ax = vx; ay = vy; az = vz;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, dcount, first;
    reset = 1'b1; start = 1'b0; ax = '0; ay = '0; az = '0;

    vecs[0] = '{"level",        16'sd0,      16'sd0,      16'sd16384,  0,     6, 0,      6, 0};
    vecs[1] = '{"roll45",       16'sd0,      16'sd11585,  16'sd11585,  0,     6, 12868,  6, 0};
    vecs[2] = '{"zero_pass1",   -16'sd16384, 16'sd0,      16'sd0,      25736, 6, 0,      0, 0};
    vecs[3] = '{"upside_down",  16'sd0,      16'sd0,      -16'sd16384, 0,     6, 32767,  0, 1};
    vecs[4] = '{"sat_clear",    16'sd0,      16'sd0,      16'sd16384,  0,     6, 0,      6, 0};
    vecs[5] = '{"pitch_neg45",  16'sd16384,  16'sd0,      16'sd16384,  -12868,6, 0,      6, 0};
    vecs[6] = '{"roll_neg45",   16'sd0,      -16'sd11585, 16'sd11585,  0,     6, -12868, 6, 0};
    vecs[7] = '{"all_zero",     16'sd0,      16'sd0,      16'sd0,      0,     0, 0,      0, 0};
    vecs[8] = '{"ax_min_neg",   -16'sd32768, 16'sd0,      16'sd0,      25736, 6, 0,      0, 0};
    vecs[9] = '{"neg_pi_clip",  16'sd0,      -16'sd1,     -16'sd16384, 0,     6, -32768, 0, 1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset phi_acc", int'(phi_acc), 0, 0);
    checkOutput("reset theta_acc", int'(theta_acc), 0, 0);
    checkOutput("reset done", int'(done), 0, 0);
    checkOutput("reset busy", int'(busy), 0, 0);
    checkOutput("reset sat", int'(sat), 0, 0);

`ifdef ACC_ANGLE_LPF_EN
    applyStimulus(16'sd0, 16'sd11585, 16'sd11585, lat);
    checkOutput("lpf first latency", lat, 32, 0);
    checkOutput("lpf first phi", int'(phi_acc), 12868, 6);
    applyStimulus(16'sd0, 16'sd0, 16'sd16384, lat);
    checkOutput("lpf second latency", lat, 32, 0);
    checkOutput("lpf second phi", int'(phi_acc), 9651, 6);
    checkOutput("lpf second theta", int'(theta_acc), 0, 6);
`else
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ax, vecs[i].ay, vecs[i].az, lat);
      checkOutput({vecs[i].name, " latency"}, lat, 32, 0);
      checkOutput({vecs[i].name, " phi"}, int'(phi_acc), vecs[i].exp_phi, vecs[i].tol_phi);
      checkOutput({vecs[i].name, " theta"}, int'(theta_acc), vecs[i].exp_theta, vecs[i].tol_theta);
      checkOutput({vecs[i].name, " sat"}, int'(sat), vecs[i].exp_sat, 0);
    end
`endif

    // Extra start pulses during ROT1 and in DONE must not restart or queue a conversion
    @(negedge clk);
    ax = 16'sd0; ay = 16'sd11585; az = 16'sd11585;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0; first = -1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) checkOutput("ignore busy early", int'(busy), 1, 0);
      if (done) begin
        dcount++;
        if (first < 0) first = c;
      end
      start = (c == 5 || c == 31);
    end
    start = 1'b0;
    checkOutput("ignore done count", dcount, 1, 0);
    checkOutput("ignore done cycle", first, 32, 0);
    checkOutput("ignore busy after", int'(busy), 0, 0);

    // Reset mid-conversion aborts with no done and clears the outputs
    @(negedge clk);
    ax = 16'sd0; ay = 16'sd0; az = -16'sd16384;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("abort phi_acc", int'(phi_acc), 0, 0);
    checkOutput("abort theta_acc", int'(theta_acc), 0, 0);
    checkOutput("abort busy", int'(busy), 0, 0);
    checkOutput("abort sat", int'(sat), 0, 0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    checkOutput("abort no done", dcount, 0, 0);

    applyStimulus(16'sd0, 16'sd11585, 16'sd11585, lat);
    checkOutput("restart latency", lat, 32, 0);
    checkOutput("restart phi", int'(phi_acc), 12868, 6);
    checkOutput("restart theta", int'(theta_acc), 0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
